alu_serial: RTL and testbench
=============================

ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving operand/result width in bits; legal values are even and at least 2.
REQ-002 SHALL have port aclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port rx_valid, input, 1 bit: request present.
REQ-005 SHALL have port tx_ready, output, 1 bit: block can accept a request.
REQ-006 SHALL have port rx_what_op, input, 5 bits: one-hot op; bit0 ADD, bit1 SUB, bit2 AND, bit3 OR, bit4 XOR.
REQ-007 SHALL have ports rx_operand0 and rx_operand1, inputs, WIDTH bits each: operands A and B.
REQ-008 SHALL have port rx_carryflag, input, 1 bit: carry-in, used by ADD only.
REQ-009 SHALL have port tx_valid, output, 1 bit: result present.
REQ-010 SHALL have port rx_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port tx_result, output, WIDTH bits: the result.
REQ-012 SHALL have ports tx_carryflag, tx_zeroflag and tx_signflag, outputs, 1 bit each: the carry, zero and sign flags.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL assert tx_ready only in IDLE and tx_valid only in DONE.
REQ-015 SHALL accept a request on an edge with IDLE, rx_valid=1, then register op, A, B and carry-in, clear the slice counter and enter RUN.
REQ-016 SHALL process 2 bits per cycle in RUN, LSB slice first, over WIDTH/2 cycles; slice i covers bits [2i+1:2i].
REQ-017 SHALL feed each slice's carry-out into the next slice's carry-in through a carry register.
REQ-018 SHALL set the first-slice carry-in to rx_carryflag for ADD, and to 1 for SUB, with B inverted, so that SUB computes A-B.
REQ-019 SHALL make AND, OR and XOR bitwise, with the carry register forced to 0.
REQ-020 SHALL enter DONE after the last slice, with tx_valid=1 exactly WIDTH/2+1 edges after the accept edge (9 edges for WIDTH=16).
REQ-021 SHALL hold in DONE: tx_carryflag = final carry-out (for SUB, 1 = no borrow); tx_zeroflag = 1 iff tx_result is all zero; tx_signflag = tx_result[WIDTH-1].
REQ-022 SHALL hold tx_result and all flags stable while tx_valid=1 and rx_ready=0.
REQ-023 SHALL return to IDLE on an edge in DONE with rx_ready=1; the next accept is possible no earlier than the following edge.
REQ-024 SHALL ignore rx_valid in RUN and DONE; registered operands SHALL be unaffected by input changes after acceptance.
REQ-025 SHALL treat a non-one-hot rx_what_op (including 0) as a legal request producing result 0, carry 0, zero 1, sign 0 with normal latency.
REQ-026 SHALL have no combinational path from any input to any output.

Reset
REQ-027 SHALL, on an edge with aresetn=0, enter IDLE, clear the counter, carry and result registers, and set tx_ready=1 (first cycle after reset), tx_valid=0, tx_result=0, tx_carryflag=0, tx_zeroflag=1 and tx_signflag=0.
REQ-028 SHALL, when reset asserts mid-RUN or in DONE, discard the operation with no output of it.

Structure
REQ-029 SHALL take the op one-hot bit positions, the FSM state enum and the default WIDTH from shared package alu_pkg.
REQ-030 SHALL instantiate sub-module alu_slice, a combinational 2-bit slice: inputs op, carry-in and two 2-bit operands; outputs a 2-bit result and carry-out.
REQ-031 SHALL use a slice counter of $clog2(WIDTH/2) bits, minimum 1.

Verification
REQ-032 SHALL check ADD A=0x7FFF, B=0x0001, cin=0 -> tx_result=0x8000, C=0, Z=0, S=1; tx_valid rises 9 edges after accept.
REQ-033 SHALL check SUB A=0x0005, B=0x0005 -> 0x0000, C=1, Z=1, S=0; and SUB A=0x0000, B=0x0001 -> 0xFFFF, C=0, S=1.
REQ-034 SHALL check ADD A=0xFFFF, B=0x0000, cin=1 -> 0x0000, C=1, Z=1.
REQ-035 SHALL check XOR A=0xA5A5, B=0xFFFF with rx_ready low for 5 cycles -> 0x5A5A held stable, tx_ready=0 throughout, IDLE one edge after rx_ready=1.
REQ-036 SHALL check reset asserted in RUN slice 4 -> all outputs equal reset values after that edge, then a new AND 0xF0F0 & 0x3C3C -> 0x3030.
REQ-037 SHALL check rx_what_op=5'b00011 -> result 0x0000, C=0, Z=1, S=0 after 9 edges.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU: op one-hot bit positions, FSM states,
// default width and the first-slice carry selection.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int OP_W          = 5;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_XOR = 4;

    localparam logic [OP_W-1:0] HOT_ADD = OP_W'(1) << OP_ADD;
    localparam logic [OP_W-1:0] HOT_SUB = OP_W'(1) << OP_SUB;
    localparam logic [OP_W-1:0] HOT_AND = OP_W'(1) << OP_AND;
    localparam logic [OP_W-1:0] HOT_OR  = OP_W'(1) << OP_OR;
    localparam logic [OP_W-1:0] HOT_XOR = OP_W'(1) << OP_XOR;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // SUB seeds a carry of 1 so that A + ~B + 1 yields A - B.
    function automatic logic first_carry(input logic [OP_W-1:0] op, input logic cin);
        if (op == HOT_ADD) begin
            return cin;
        end else if (op == HOT_SUB) begin
            return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational 2-bit ALU slice. Any op that is not exactly one-hot
// produces a zero result and zero carry-out.
module alu_slice
    import alu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic            cin,
    input  logic [1:0]      a,
    input  logic [1:0]      b,
    output logic [1:0]      res,
    output logic            cout
);

    logic [2:0] sum;

    always_comb begin
        sum  = 3'b000;
        res  = 2'b00;
        cout = 1'b0;
        case (op)
            HOT_ADD: begin
                sum  = {1'b0, a} + {1'b0, b} + {2'b00, cin};
                res  = sum[1:0];
                cout = sum[2];
            end
            HOT_SUB: begin
                sum  = {1'b0, a} + {1'b0, ~b} + {2'b00, cin};
                res  = sum[1:0];
                cout = sum[2];
            end
            HOT_AND: res = a & b;
            HOT_OR:  res = a | b;
            HOT_XOR: res = a ^ b;
            default: res = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Serial ALU: processes two bits per cycle LSB first, then presents the
// result with carry/zero/sign flags under a valid/ready handshake.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             rx_valid,
    output logic             tx_ready,
    input  logic [OP_W-1:0]  rx_what_op,
    input  logic [WIDTH-1:0] rx_operand0,
    input  logic [WIDTH-1:0] rx_operand1,
    input  logic             rx_carryflag,
    output logic             tx_valid,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] tx_result,
    output logic             tx_carryflag,
    output logic             tx_zeroflag,
    output logic             tx_signflag
);

    localparam int SLICES = WIDTH / 2;
    localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(SLICES - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic             last_reg;
    logic [OP_W-1:0]  op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] result_reg;
    logic             cflag_reg;
    logic             zflag_reg;
    logic             sflag_reg;
    logic             ready_reg;
    logic             valid_reg;

    logic [1:0]       slice_res;
    logic             slice_cout;

    alu_slice u_slice (
        .op   (op_reg),
        .cin  (carry_reg),
        .a    (a_reg[1:0]),
        .b    (b_reg[1:0]),
        .res  (slice_res),
        .cout (slice_cout)
    );

    // RUN takes SLICES cycles of slice work plus one cycle that latches the
    // assembled result and its flags into the output registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            last_reg   <= 1'b0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
            cflag_reg  <= 1'b0;
            zflag_reg  <= 1'b1;
            sflag_reg  <= 1'b0;
            ready_reg  <= 1'b1;
            valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rx_valid) begin
                        op_reg    <= rx_what_op;
                        a_reg     <= rx_operand0;
                        b_reg     <= rx_operand1;
                        carry_reg <= first_carry(rx_what_op, rx_carryflag);
                        cnt_reg   <= '0;
                        last_reg  <= 1'b0;
                        acc_reg   <= '0;
                        ready_reg <= 1'b0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (last_reg) begin
                        result_reg <= acc_reg;
                        cflag_reg  <= carry_reg;
                        zflag_reg  <= (acc_reg == '0);
                        sflag_reg  <= acc_reg[WIDTH-1];
                        valid_reg  <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        a_reg     <= a_reg >> 2;
                        b_reg     <= b_reg >> 2;
                        acc_reg   <= (acc_reg >> 2) | (WIDTH'(slice_res) << (WIDTH - 2));
                        carry_reg <= slice_cout;
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == LAST_SLICE) begin
                            last_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (rx_ready) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready     = ready_reg;
    assign tx_valid     = valid_reg;
    assign tx_result    = result_reg;
    assign tx_carryflag = cflag_reg;
    assign tx_zeroflag  = zflag_reg;
    assign tx_signflag  = sflag_reg;

endmodule

// File: tb/tb_alu_serial.sv
// Randomized and directed bench for alu_serial: a driver queues expected
// results from an arithmetic reference model; a monitor pops and compares.
module tb_alu_serial;

    localparam int W = 16;

    logic         aclk;
    logic         aresetn;
    logic         rx_valid;
    logic         tx_ready;
    logic [4:0]   rx_what_op;
    logic [W-1:0] rx_operand0;
    logic [W-1:0] rx_operand1;
    logic         rx_carryflag;
    logic         tx_valid;
    logic         rx_ready;
    logic [W-1:0] tx_result;
    logic         tx_carryflag;
    logic         tx_zeroflag;
    logic         tx_signflag;

    alu_serial #(.WIDTH(W)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .rx_valid     (rx_valid),
        .tx_ready     (tx_ready),
        .rx_what_op   (rx_what_op),
        .rx_operand0  (rx_operand0),
        .rx_operand1  (rx_operand1),
        .rx_carryflag (rx_carryflag),
        .tx_valid     (tx_valid),
        .rx_ready     (rx_ready),
        .tx_result    (tx_result),
        .tx_carryflag (tx_carryflag),
        .tx_zeroflag  (tx_zeroflag),
        .tx_signflag  (tx_signflag)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         s;
        logic [4:0]   op;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   rd_ptr   = 0;
    int   done_cnt = 0;
    logic rst_at_edge = 1'b1;

    always @(posedge aclk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !aresetn;
    end

    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t       e;
        logic [W:0] t;
        e.r = '0;
        e.c = 1'b0;
        case (op)
            5'b00001: begin
                t   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                e.r = t[W-1:0];
                e.c = t[W];
            end
            5'b00010: begin
                e.r = a - b;
                e.c = (a >= b);
            end
            5'b00100: e.r = a & b;
            5'b01000: e.r = a | b;
            5'b10000: e.r = a ^ b;
            default:  e.r = '0;
        endcase
        e.z   = (e.r == '0);
        e.s   = e.r[W-1];
        e.op  = op;
        e.acc = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every completed result against the scoreboard head.
    logic         seen = 1'b0;
    logic         post = 1'b0;
    logic [W+2:0] snap;

    always @(negedge aclk) begin
        if (rst_at_edge) begin
            check("rst_tx_ready", 32'(tx_ready), 32'd1);
            check("rst_tx_valid", 32'(tx_valid), 32'd0);
            check("rst_tx_result", 32'(tx_result), 32'd0);
            check("rst_carry", 32'(tx_carryflag), 32'd0);
            check("rst_zero", 32'(tx_zeroflag), 32'd1);
            check("rst_sign", 32'(tx_signflag), 32'd0);
            rd_ptr = sb.size();
            seen   = 1'b0;
            post   = 1'b0;
        end else begin
            if (post) begin
                check("idle_after_ack", 32'({tx_valid, tx_ready}), 32'b01);
                post = 1'b0;
            end
            if (tx_valid) begin
                check("ready_in_done", 32'(tx_ready), 32'd0);
                if (!seen) begin
                    seen = 1'b1;
                    snap = {tx_result, tx_carryflag, tx_zeroflag, tx_signflag};
                    if (rd_ptr >= sb.size())
                        check("unexpected_valid", 32'd1, 32'd0);
                    else
                        check("latency", 32'(cyc - sb[rd_ptr].acc), 32'(W/2 + 1));
                end else begin
                    check("hold_stable", 32'({tx_result, tx_carryflag, tx_zeroflag, tx_signflag}),
                          32'(snap));
                end
                if (rx_ready) begin
                    if (rd_ptr < sb.size()) begin
                        $display("[TB] op=%b result=%h C=%b Z=%b S=%b (exp %h %b %b %b)",
                                 sb[rd_ptr].op, tx_result, tx_carryflag, tx_zeroflag, tx_signflag,
                                 sb[rd_ptr].r, sb[rd_ptr].c, sb[rd_ptr].z, sb[rd_ptr].s);
                        check("result", 32'(tx_result), 32'(sb[rd_ptr].r));
                        check("carry", 32'(tx_carryflag), 32'(sb[rd_ptr].c));
                        check("zero", 32'(tx_zeroflag), 32'(sb[rd_ptr].z));
                        check("sign", 32'(tx_signflag), 32'(sb[rd_ptr].s));
                        rd_ptr++;
                    end
                    done_cnt++;
                    seen = 1'b0;
                    post = 1'b1;
                end
            end else if (seen) begin
                check("valid_dropped", 32'd0, 32'd1);
                seen = 1'b0;
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin);
        exp_t e;
        int   guard = 0;
        while (!tx_ready && guard < 50) begin
            @(posedge aclk); #1;
            guard++;
        end
        if (!tx_ready) begin
            $display("FAIL accept_timeout: tx_ready still 0 after %0d cycles, required 1", guard);
            $fatal(1, "accept timeout");
        end
        rx_valid     = 1'b1;
        rx_what_op   = op;
        rx_operand0  = a;
        rx_operand1  = b;
        rx_carryflag = cin;
        @(posedge aclk); #1;
        e     = model(op, a, b, cin);
        e.acc = cyc;
        sb.push_back(e);
        // Scramble inputs after acceptance; the registered copies must not follow.
        rx_valid     = 1'b0;
        rx_what_op   = 5'($urandom);
        rx_operand0  = W'($urandom);
        rx_operand1  = W'($urandom);
        rx_carryflag = 1'($urandom);
    endtask

    task automatic wait_done(input bit rand_ready);
        int start = done_cnt;
        int guard = 0;
        while (done_cnt == start && guard < 100) begin
            if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
            @(posedge aclk); #1;
            guard++;
        end
        rx_ready = 1'b1;
        if (done_cnt == start) begin
            $display("FAIL done_timeout: no result after %0d cycles, required within 100", guard);
            $fatal(1, "result timeout");
        end
    endtask

    task automatic run(input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin);
        issue(op, a, b, cin);
        wait_done(1'b0);
    endtask

    initial begin
        int         guard;
        logic [4:0] op;
        aresetn      = 1'b0;
        rx_valid     = 1'b0;
        rx_ready     = 1'b1;
        rx_what_op   = '0;
        rx_operand0  = '0;
        rx_operand1  = '0;
        rx_carryflag = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;

        run(5'b00001, 16'h7FFF, 16'h0001, 1'b0);
        run(5'b00010, 16'h0005, 16'h0005, 1'b0);
        run(5'b00010, 16'h0000, 16'h0001, 1'b0);
        run(5'b00001, 16'hFFFF, 16'h0000, 1'b1);
        run(5'b00011, 16'h1234, 16'h5678, 1'b1);
        run(5'b00000, 16'hFFFF, 16'hFFFF, 1'b0);

        // Consumer stalls five cycles on an XOR result.
        rx_ready = 1'b0;
        issue(5'b10000, 16'hA5A5, 16'hFFFF, 1'b0);
        guard = 0;
        while (!tx_valid && guard < 50) begin
            @(posedge aclk); #1;
            guard++;
        end
        repeat (5) @(posedge aclk);
        #1 rx_ready = 1'b1;
        wait_done(1'b0);

        // Reset while slice 4 is in progress: the pending result is discarded.
        issue(5'b00001, 16'h1357, 16'h2468, 1'b0);
        repeat (4) @(posedge aclk);
        #1 aresetn = 1'b0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        run(5'b00100, 16'hF0F0, 16'h3C3C, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) op = 5'($urandom);
            else                           op = 5'(1) << $urandom_range(0, 4);
            issue(op, W'($urandom), W'($urandom), 1'($urandom));
            wait_done(1'b1);
        end

        repeat (4) @(posedge aclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
